// File: rtl/load_pkg.sv
// Shared load-path constants: load-type codes, FSM states, byte-lane layout.
// Misalignment helper is used only when LOAD_ALIGN_EXC_EN is defined.
package load_pkg;

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LHU = 3'b010;
  localparam logic [2:0] LD_LB  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;

  localparam int LANE_W = 8;
  localparam int LANES  = 4;

  localparam logic [1:0] OFF_B0 = 2'b00;
  localparam logic [1:0] OFF_H1 = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } ld_state_e;

  function automatic logic misaligned(
    input logic [2:0] t,
    input logic [1:0] off
  );
    logic bad;
    unique case (1'b1)
      (t == LD_LH),
      (t == LD_LHU): bad = off[0];
      (t == LD_LB),
      (t == LD_LBU): bad = 1'b0;
      default:       bad = (off != OFF_B0);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Lane select and sign/zero extension of a returned memory word.
// Unknown type codes behave as LW.
module load_extend
  import load_pkg::*;
(
  input  logic [2:0]  ld_type,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  lane;
  logic [15:0] half;

  always_comb begin
    lane = word[off*LANE_W +: LANE_W];
    half = (off == OFF_H1) ? word[31:16]
                           : word[15:0];
    unique case (1'b1)
      (ld_type == LD_LH):
        result = {{16{half[15]}}, half};
      (ld_type == LD_LHU):
        result = {16'h0, half};
      (ld_type == LD_LB):
        result = {{24{lane[7]}}, lane};
      (ld_type == LD_LBU):
        result = {24'h0, lane};
      default:
        result = word;
    endcase
  end

endmodule

// File: rtl/load_data_unit.sv
// Single-outstanding load unit: word read, lane extract, tagged writeback.
// Define LOAD_ALIGN_EXC_EN to trap misaligned LW/LH/LHU instead of reading.
module load_data_unit
  import load_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_type,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic              flush,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              resp_exc
);

  ld_state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        type_q;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] ext;
  logic              bad;
  logic              take;

  load_extend u_ext (
    .ld_type (type_q),
    .off     (addr_q[1:0]),
    .word    (mem_rdata),
    .result  (ext)
  );

`ifdef LOAD_ALIGN_EXC_EN
  logic exc_q;
  assign bad      = misaligned(type_q, addr_q[1:0]);
  assign resp_exc = exc_q;
`else
  assign bad      = 1'b0;
  assign resp_exc = 1'b0;
`endif

  assign take = (state_q == S_IDLE) && req_valid && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (take) state_d = S_ISSUE;
      S_ISSUE:
        if (flush)              state_d = S_IDLE;
        else if (bad)           state_d = S_RESP;
        else if (mem_req_ready) state_d = S_WAIT;
      S_WAIT:
        // a flush coinciding with the data pulse has nothing left to drain
        if (flush)
          state_d = mem_rvalid ? S_IDLE : S_DRAIN;
        else if (mem_rvalid)
          state_d = S_RESP;
      S_RESP:
        if (flush || resp_ready) state_d = S_IDLE;
      S_DRAIN:
        if (mem_rvalid) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      type_q <= '0;
      tag_q  <= '0;
      data_q <= '0;
`ifdef LOAD_ALIGN_EXC_EN
      exc_q  <= 1'b0;
`endif
    end else begin
      if (take) begin
        addr_q <= req_addr;
        type_q <= req_type;
        tag_q  <= req_tag;
      end
      if (state_q == S_WAIT && mem_rvalid && !flush) begin
        data_q <= ext;
`ifdef LOAD_ALIGN_EXC_EN
        exc_q  <= 1'b0;
`endif
      end
`ifdef LOAD_ALIGN_EXC_EN
      if (state_q == S_ISSUE && !flush && bad) begin
        data_q <= addr_q[31:0];
        exc_q  <= 1'b1;
      end
`endif
    end
  end

  always_comb begin
    req_ready     = rst_n && (state_q == S_IDLE) && !flush;
    mem_req_valid = (state_q == S_ISSUE) && !flush && !bad;
    resp_valid    = (state_q == S_RESP) && !flush;
  end

  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign resp_data = data_q;
  assign resp_tag  = tag_q;

endmodule

// File: tb/tb_load_data_unit.sv
// Self-checking bench for load_data_unit: directed, flush, reset, random.
// Honours LOAD_ALIGN_EXC_EN when the same macro is set for the build.
module tb_load_data_unit;

`ifdef LOAD_ALIGN_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_type;
  logic [4:0]  req_tag;
  logic        flush;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;
  logic        resp_exc;

  int n_checks = 0;
  int n_pass   = 0;

  load_data_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_type      (req_type),
    .req_tag       (req_tag),
    .flush         (flush),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .resp_tag      (resp_tag),
    .resp_exc      (resp_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: rules applied with plain arithmetic on the byte address.
  function automatic bit ref_exc(input logic [2:0] t, input logic [31:0] a);
    int off;
    off = a % 4;
    if (!EXC_EN) return 1'b0;
    if (t == 3'd1 || t == 3'd2) return (off % 2) == 1;
    if (t == 3'd3 || t == 3'd4) return 1'b0;
    return off != 0;
  endfunction

  function automatic logic [31:0] ref_data(
    input logic [2:0] t, input logic [31:0] a, input logic [31:0] w
  );
    int unsigned off;
    longint unsigned lane, half, wl;
    logic [31:0] r;
    off  = a % 4;
    wl   = w;
    lane = (wl / (64'd1 << (8 * off))) % 256;
    half = (off == 2) ? wl / 65536 : wl % 65536;
    case (t)
      3'd1:    r = (half >= 32768) ? 32'(half) + 32'hFFFF_0000 : 32'(half);
      3'd2:    r = 32'(half);
      3'd3:    r = (lane >= 128) ? 32'(lane) + 32'hFFFF_FF00 : 32'(lane);
      3'd4:    r = 32'(lane);
      default: r = w;
    endcase
    if (ref_exc(t, a)) r = a;
    return r;
  endfunction

  // Drives one load through memory and writeback; records what was seen.
  task automatic run_load(
    input  logic [31:0] a, input logic [2:0] t, input logic [4:0] g,
    input  logic [31:0] w, input int mw, input int rw,
    output logic [31:0] d, output logic [4:0] og, output logic ox,
    output logic [31:0] ma, output int lat, output bit stable,
    output bit ok, output bit mem_seen
  );
    int mcnt, rcnt;
    bit hs;
    logic [31:0] d0;
    logic [4:0] g0;
    stable = 1; ok = 0; lat = 0; mem_seen = 0; hs = 0;
    mcnt = 0; rcnt = 0; d = '0; og = '0; ox = 0; ma = '0;
    d0 = '0; g0 = '0;
    @(negedge clk);
    req_valid = 1; req_addr = a; req_type = t; req_tag = g;
    if (req_ready !== 1'b1) stable = 0;
    for (int c = 1; c < 64 && !ok; c++) begin
      @(negedge clk);
      req_valid = 0;
      req_addr = $urandom; req_type = 3'($urandom); req_tag = 5'($urandom);
      mem_rvalid = 0; mem_req_ready = 0; resp_ready = 0;
      mem_rdata = $urandom;
      if (req_ready !== 1'b0) stable = 0;
      if (hs) begin
        mem_rvalid = 1; mem_rdata = w; hs = 0;
      end
      if (mem_req_valid) begin
        if (!mem_seen) ma = mem_addr;
        else if (mem_addr !== ma) stable = 0;
        mem_seen = 1;
        if (mcnt < mw) mcnt++;
        else begin mem_req_ready = 1; hs = 1; end
      end
      if (resp_valid) begin
        if (lat == 0) begin lat = c; d0 = resp_data; g0 = resp_tag; end
        else if (resp_data !== d0 || resp_tag !== g0) stable = 0;
        if (rcnt < rw) rcnt++;
        else begin
          resp_ready = 1; d = resp_data; og = resp_tag; ox = resp_exc;
          ok = 1;
        end
      end
    end
    @(negedge clk);
    resp_ready = 0; mem_req_ready = 0; mem_rvalid = 0;
  endtask

  task automatic test_reset;
    rst_n = 0; req_valid = 0; req_addr = '0; req_type = '0; req_tag = '0;
    flush = 0; mem_req_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    resp_ready = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0)
      $display("FAIL reset_req_ready got %b want 0", req_ready);
    else n_pass++;
    n_checks++;
    if ({mem_req_valid, resp_valid, resp_exc, mem_addr, resp_data, resp_tag} !== '0)
      $display("FAIL reset_outputs got mv=%b rv=%b ex=%b ma=%h rd=%h rt=%h want all 0",
               mem_req_valid, resp_valid, resp_exc, mem_addr, resp_data, resp_tag);
    else n_pass++;
    rst_n = 1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1)
      $display("FAIL reset_release_ready got %b want 1", req_ready);
    else n_pass++;
  endtask

  task automatic test_directed;
    logic [31:0] d, ma; logic [4:0] g; logic x; int lat; bit st, ok, ms;
    run_load(32'h0000_0003, 3'd3, 5'd9, 32'h80FF_1234, 0, 0,
             d, g, x, ma, lat, st, ok, ms);
    n_checks++;
    if (d !== 32'hFFFF_FF80 || g !== 5'd9 || !ok)
      $display("FAIL lb_sign got %h tag %0d ok %0d want ffffff80 tag 9", d, g, ok);
    else n_pass++;
    n_checks++;
    if (lat !== 3)
      $display("FAIL lb_latency got %0d want 3", lat);
    else n_pass++;
    run_load(32'h0000_1002, 3'd2, 5'd1, 32'h8001_7FFF, 0, 0,
             d, g, x, ma, lat, st, ok, ms);
    n_checks++;
    if (d !== 32'h0000_8001 || !ok)
      $display("FAIL lhu_hi got %h want 00008001", d);
    else n_pass++;
    run_load(32'h0000_1000, 3'd1, 5'd2, 32'h8001_7FFF, 0, 0,
             d, g, x, ma, lat, st, ok, ms);
    n_checks++;
    if (d !== 32'h0000_7FFF || !ok)
      $display("FAIL lh_lo got %h want 00007fff", d);
    else n_pass++;
    run_load(32'h0000_1002, 3'd1, 5'd3, 32'h8001_7FFF, 0, 0,
             d, g, x, ma, lat, st, ok, ms);
    n_checks++;
    if (d !== 32'hFFFF_8001 || !ok)
      $display("FAIL lh_hi got %h want ffff8001", d);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    logic [31:0] d, ma; logic [4:0] g; logic x; int lat; bit st, ok, ms;
    run_load(32'hABCD_0126, 3'd4, 5'd17, 32'h1122_3344, 4, 3,
             d, g, x, ma, lat, st, ok, ms);
    n_checks++;
    if (!st || !ok)
      $display("FAIL bp_stable got stable=%0d ok=%0d want 1 1", st, ok);
    else n_pass++;
    n_checks++;
    if (ma !== 32'hABCD_0124 || d !== 32'h0000_0022 || g !== 5'd17)
      $display("FAIL bp_values got addr %h data %h tag %0d want abcd0124 00000022 17",
               ma, d, g);
    else n_pass++;
    n_checks++;
    if (lat !== 7)
      $display("FAIL bp_latency got %0d want 7", lat);
    else n_pass++;
  endtask

  task automatic test_flush_idle;
    @(negedge clk);
    req_valid = 1; req_addr = 32'h40; req_type = 3'd0; flush = 1;
    #1;
    n_checks++;
    if (req_ready !== 1'b0)
      $display("FAIL flush_idle_ready got %b want 0", req_ready);
    else n_pass++;
    @(negedge clk);
    req_valid = 0; flush = 0;
    #1;
    n_checks++;
    if (mem_req_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL flush_idle_accept got mv=%b rr=%b want 0 1",
               mem_req_valid, req_ready);
    else n_pass++;
  endtask

  task automatic test_flush_issue;
    @(negedge clk);
    req_valid = 1; req_addr = 32'h80; req_type = 3'd0; req_tag = 5'd4;
    @(negedge clk);
    req_valid = 0; flush = 1; mem_req_ready = 1;
    #1;
    n_checks++;
    if (mem_req_valid !== 1'b0)
      $display("FAIL flush_issue_mv got %b want 0", mem_req_valid);
    else n_pass++;
    @(negedge clk);
    flush = 0; mem_req_ready = 0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || mem_req_valid !== 1'b0)
      $display("FAIL flush_issue_idle got rr=%b mv=%b want 1 0",
               req_ready, mem_req_valid);
    else n_pass++;
  endtask

  task automatic test_flush_wait;
    bit bad_rv, bad_rr;
    bad_rv = 0; bad_rr = 0;
    @(negedge clk);
    req_valid = 1; req_addr = 32'hC0; req_type = 3'd0; req_tag = 5'd5;
    @(negedge clk);
    req_valid = 0; mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0; flush = 1;
    @(negedge clk);
    flush = 0;
    if (resp_valid) bad_rv = 1;
    if (req_ready) bad_rr = 1;
    @(negedge clk);
    if (resp_valid) bad_rv = 1;
    if (req_ready) bad_rr = 1;
    mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_rvalid = 0;
    if (resp_valid) bad_rv = 1;
    n_checks++;
    if (bad_rv || bad_rr)
      $display("FAIL flush_wait_drain got resp_valid_seen=%0d ready_seen=%0d want 0 0",
               bad_rv, bad_rr);
    else n_pass++;
    n_checks++;
    if (req_ready !== 1'b1)
      $display("FAIL flush_wait_exit got rr=%b want 1", req_ready);
    else n_pass++;
  endtask

  task automatic test_flush_resp;
    @(negedge clk);
    req_valid = 1; req_addr = 32'h100; req_type = 3'd0; req_tag = 5'd6;
    @(negedge clk);
    req_valid = 0; mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_rvalid = 0; flush = 1; resp_ready = 1;
    #1;
    n_checks++;
    if (resp_valid !== 1'b0)
      $display("FAIL flush_resp_rv got %b want 0", resp_valid);
    else n_pass++;
    @(negedge clk);
    flush = 0; resp_ready = 0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0)
      $display("FAIL flush_resp_idle got rr=%b rv=%b want 1 0", req_ready, resp_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] d, ma; logic [4:0] g; logic x; int lat; bit st, ok, ms;
    run_load(32'h0000_2001, 3'd4, 5'd30, 32'h00A5_5A00, 0, 0,
             d, g, x, ma, lat, st, ok, ms);
    n_checks++;
    if (d !== 32'h0000_005A || g !== 5'd30 || lat !== 3 || !ok)
      $display("FAIL after_flush got %h tag %0d lat %0d want 0000005a 30 3", d, g, lat);
    else n_pass++;
  endtask

  task automatic test_reset_resp;
    @(negedge clk);
    req_valid = 1; req_addr = 32'h44; req_type = 3'd0; req_tag = 5'd7;
    @(negedge clk);
    req_valid = 0; mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0; mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rvalid = 0;
    n_checks++;
    if (resp_valid !== 1'b1 || resp_data !== 32'hDEAD_BEEF)
      $display("FAIL rst_resp_setup got rv=%b rd=%h want 1 deadbeef",
               resp_valid, resp_data);
    else n_pass++;
    #2 rst_n = 0;
    #1;
    n_checks++;
    if ({req_ready, mem_req_valid, resp_valid, resp_exc,
         mem_addr, resp_data, resp_tag} !== '0)
      $display("FAIL rst_async got rr=%b rv=%b ma=%h rd=%h rt=%h want all 0",
               req_ready, resp_valid, mem_addr, resp_data, resp_tag);
    else n_pass++;
    @(negedge clk);
    rst_n = 1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0)
      $display("FAIL rst_idle got rr=%b rv=%b want 1 0", req_ready, resp_valid);
    else n_pass++;
  endtask

  task automatic test_align;
    logic [31:0] d, ma; logic [4:0] g; logic x; int lat; bit st, ok, ms;
    run_load(32'h0000_3001, 3'd0, 5'd12, 32'hA5A5_0F0F, 0, 0,
             d, g, x, ma, lat, st, ok, ms);
    n_checks++;
    if (ms !== !EXC_EN)
      $display("FAIL align_memreq got seen=%0d want %0d", ms, !EXC_EN);
    else n_pass++;
    n_checks++;
    if (x !== EXC_EN || d !== (EXC_EN ? 32'h0000_3001 : 32'hA5A5_0F0F) || !ok)
      $display("FAIL align_result got exc=%b data=%h want exc=%b", x, d, EXC_EN);
    else n_pass++;
  endtask

  task automatic test_random;
    logic [31:0] d, ma, a, w; logic [4:0] g, tg; logic x; logic [2:0] t;
    int lat, mw, rw, elat; bit st, ok, ms, ex;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; w = $urandom; t = 3'($urandom_range(0, 7));
      tg = 5'($urandom); mw = $urandom_range(0, 2); rw = $urandom_range(0, 2);
      ex = ref_exc(t, a);
      elat = ex ? 2 : 3 + mw;
      run_load(a, t, tg, w, mw, rw, d, g, x, ma, lat, st, ok, ms);
      n_checks++;
      if (!ok || d !== ref_data(t, a, w) || g !== tg || x !== ex)
        $display("FAIL rand_%0d got d=%h tag=%0d exc=%b want d=%h tag=%0d exc=%b",
                 i, d, g, x, ref_data(t, a, w), tg, ex);
      else n_pass++;
      n_checks++;
      if (lat !== elat || !st || (!ex && ma !== {a[31:2], 2'b00}))
        $display("FAIL rand_timing_%0d got lat=%0d stable=%0d addr=%h want lat=%0d",
                 i, lat, st, ma, elat);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_flush_idle;
    test_flush_issue;
    test_flush_wait;
    test_flush_resp;
    test_back_to_back;
    test_reset_resp;
    test_align;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
